// File: rtl/pdl_crp_sequencer_if.sv
// CRP output stream from the PUF challenge sequencer to the host capture logic.
// The master drives the challenge/response pair; the slave applies backpressure with crp_ready.
interface pdl_crp_sequencer_if;
  logic         crp_valid;
  logic         crp_ready;
  logic [127:0] crp_challenge;
  logic [15:0]  crp_response;
  logic [15:0]  crp_stable;

  modport master (
    output crp_valid,
    output crp_challenge,
    output crp_response,
    output crp_stable,
    input  crp_ready
  );

  modport slave (
    input  crp_valid,
    input  crp_challenge,
    input  crp_response,
    input  crp_stable,
    output crp_ready
  );
endinterface

// File: rtl/pdl_crp_sequencer.sv
// Challenge-side driver for the 16-instance PDL PUF array: LFSR challenges, majority-voted responses.
// Optional feature macro: PDL_STABILITY_EN (per-bit "all votes agreed" flags on crp_stable).
module pdl_crp_sequencer #(
  parameter int           SETTLE_CYC = 8,
  parameter int           VOTES      = 5,
  parameter logic [127:0] LFSR_SEED  = 128'h1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  num_crp,
  output logic         busy,
  output logic         done,
  output logic [127:0] challenge,
  output logic         trigger,
  input  logic [15:0]  response,
  pdl_crp_sequencer_if.master crp
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, FIRE, EMIT, FIN} state_t;

  localparam logic [127:0] SEED    = (LFSR_SEED == 128'h0) ? 128'h1 : LFSR_SEED;
  // Galois taps for x^128+x^126+x^101+x^99+1, right-shifting form.
  localparam logic [127:0] TAPS    = 128'hA0000014_00000000_00000000_00000000;
  localparam int           TW      = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [3:0]   VOTES_L = 4'(VOTES);
  localparam logic [3:0]   HALF    = 4'(VOTES / 2);

  state_t         state_reg, state_next;
  logic           busy_reg, done_reg, trigger_reg, crp_valid_reg;
  logic [TW-1:0]  timer_reg;
  logic [3:0]     vote_reg;
  logic [15:0]    remaining_reg;
  logic [127:0]   lfsr_reg, challenge_reg, crp_challenge_reg;
  logic [15:0]    crp_response_reg, crp_stable_reg;
  logic [15:0]    resp_meta_reg, resp_sync_reg;
  logic [3:0]     cnt_reg [16];
  logic [3:0]     cnt_sum [16];
  logic [15:0]    maj_bit;
  logic           settle_last, vote_last;

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 128'h0);
  endfunction

  assign settle_last = (timer_reg == TW'(SETTLE_CYC - 1));
  assign vote_last   = (vote_reg == VOTES_L - 4'd1);

  // The vote counters are updated on the final FIRE cycle, so the verdict uses the post-add sum.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      assign cnt_sum[gi] = cnt_reg[gi] + {3'b000, resp_sync_reg[gi]};
      assign maj_bit[gi] = (cnt_sum[gi] > HALF);
    end
  endgenerate

`ifdef PDL_STABILITY_EN
  logic [15:0] stab_bit;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_stab
      assign stab_bit[gi] = (cnt_sum[gi] == 4'd0) || (cnt_sum[gi] == VOTES_L);
    end
  endgenerate
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (num_crp == 16'd0) ? FIN : LOAD;
      LOAD: state_next = ARM;
      ARM:  if (settle_last) state_next = FIRE;
      FIRE: if (settle_last) state_next = vote_last ? EMIT : ARM;
      EMIT: if (crp.crp_ready) state_next = (remaining_reg > 16'd1) ? LOAD : FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      trigger_reg       <= 1'b0;
      crp_valid_reg     <= 1'b0;
      timer_reg         <= '0;
      vote_reg          <= '0;
      remaining_reg     <= '0;
      lfsr_reg          <= '0;
      challenge_reg     <= '0;
      crp_challenge_reg <= '0;
      crp_response_reg  <= '0;
      crp_stable_reg    <= '0;
      resp_meta_reg     <= '0;
      resp_sync_reg     <= '0;
      for (int i = 0; i < 16; i++) cnt_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      // Status and trigger flops are loaded from the next state so they align with the state itself.
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == FIN);
      trigger_reg   <= (state_next == FIRE);
      crp_valid_reg <= (state_next == EMIT);
      resp_meta_reg <= response;
      resp_sync_reg <= resp_meta_reg;
      timer_reg     <= ((state_reg == ARM || state_reg == FIRE) && !settle_last) ?
                       timer_reg + TW'(1) : '0;
`ifndef PDL_STABILITY_EN
      crp_stable_reg <= 16'hFFFF;
`endif
      case (state_reg)
        IDLE: if (start) begin
          lfsr_reg      <= SEED;
          remaining_reg <= num_crp;
        end
        LOAD: begin
          challenge_reg <= lfsr_reg;
          vote_reg      <= '0;
          for (int i = 0; i < 16; i++) cnt_reg[i] <= '0;
        end
        FIRE: if (settle_last) begin
          vote_reg <= vote_reg + 4'd1;
          for (int i = 0; i < 16; i++) cnt_reg[i] <= cnt_sum[i];
          if (vote_last) begin
            crp_challenge_reg <= challenge_reg;
            crp_response_reg  <= maj_bit;
`ifdef PDL_STABILITY_EN
            crp_stable_reg    <= stab_bit;
`endif
          end
        end
        EMIT: if (crp.crp_ready) begin
          lfsr_reg      <= lfsr_step(lfsr_reg);
          remaining_reg <= remaining_reg - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign trigger           = trigger_reg;
  assign challenge         = challenge_reg;
  assign crp.crp_valid     = crp_valid_reg;
  assign crp.crp_challenge = crp_challenge_reg;
  assign crp.crp_response  = crp_response_reg;
  assign crp.crp_stable    = crp_stable_reg;

endmodule

// File: tb/tb_pdl_crp_sequencer.sv
// Scoreboard bench for pdl_crp_sequencer: directed runs push expected CRPs, a monitor pops on transfer.
module tb_pdl_crp_sequencer;

  typedef struct packed {
    logic [127:0] ch;
    logic [15:0]  rsp;
    logic [15:0]  stb;
  } crp_t;

  localparam logic [127:0] CH0 = 128'h1;
  localparam logic [127:0] CH1 = 128'hA0000014_00000000_00000000_00000000;
  localparam logic [127:0] CH2 = 128'h5000000A_00000000_00000000_00000000;
`ifdef PDL_STABILITY_EN
  localparam logic [15:0]  STAB_MIXED = 16'h0000;
`else
  localparam logic [15:0]  STAB_MIXED = 16'hFFFF;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  num_crp;
  logic         busy, done, trigger;
  logic [127:0] challenge;
  logic [15:0]  response;

  pdl_crp_sequencer_if crp_if ();

  pdl_crp_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_crp   (num_crp),
    .busy      (busy),
    .done      (done),
    .challenge (challenge),
    .trigger   (trigger),
    .response  (response),
    .crp       (crp_if)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;
  int   done_count = 0;
  int   pulses = 0;
  int   width = 0;
  int   width_bad = 0;
  int   valid_rises = 0;
  int   mode = 0;
  logic [15:0] resp_a = 16'h0;
  logic [15:0] resp_b = 16'h0;
  crp_t sb[$];

  logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_trig = 1'b0;
  logic [159:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // PUF model: vote number is the count of trigger pulses seen in this run.
  always_comb response = (mode == 1 && pulses >= 4) ? resp_b : resp_a;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Monitor: samples 1 ns after the falling edge, after the stimulus has settled.
  always begin
    crp_t e;
    @(negedge clk);
    #1;
    if (!reset) begin
      prev_valid = 1'b0;
      prev_trig  = 1'b0;
    end else begin
      if (crp_if.crp_valid && prev_valid && !prev_ready)
        check("stall_hold", {crp_if.crp_challenge, crp_if.crp_response, crp_if.crp_stable}, prev_data);
      if (crp_if.crp_valid && crp_if.crp_ready) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_crp: got challenge %0h expected none", crp_if.crp_challenge);
        end else begin
          e = sb.pop_front();
          check("crp_challenge", {32'h0, crp_if.crp_challenge}, {32'h0, e.ch});
          check("crp_response", {144'h0, crp_if.crp_response}, {144'h0, e.rsp});
          check("crp_stable", {144'h0, crp_if.crp_stable}, {144'h0, e.stb});
        end
      end
      if (crp_if.crp_valid && !prev_valid) valid_rises++;
      if (trigger && !prev_trig) begin
        pulses++;
        width = 1;
      end else if (trigger) begin
        width++;
      end else if (prev_trig && width != 8) begin
        width_bad++;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_valid = crp_if.crp_valid;
      prev_ready = crp_if.crp_ready;
      prev_trig  = trigger;
      prev_data  = {crp_if.crp_challenge, crp_if.crp_response, crp_if.crp_stable};
    end
  end

  task automatic run_start(input logic [15:0] n);
    @(negedge clk);
    start     = 1'b1;
    num_crp   = n;
    start_cyc = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_count;
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #2;
      if (done_count != d0) seen = 1'b1;
    end
    check({name, "_done_seen"}, {159'h0, seen}, {159'h0, 1'b1});
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #2;
      if (crp_if.crp_valid) seen = 1'b1;
    end
    check("valid_seen", {159'h0, seen}, {159'h0, 1'b1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b1;
    num_crp = 16'd5;
    crp_if.crp_ready = 1'b1;

    // 1: reset held with start asserted.
    repeat (3) @(negedge clk);
    #2;
    check("rst_status", {157'h0, busy, done, trigger}, 160'h0);
    check("rst_challenge", {32'h0, challenge}, 160'h0);
    check("rst_crp", {crp_if.crp_valid, crp_if.crp_challenge, crp_if.crp_response, crp_if.crp_stable}, 160'h0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("idle_after_rst", {157'h0, busy, trigger, crp_if.crp_valid}, 160'h0);
    check("idle_no_pulses", 160'(pulses), 160'd0);

    // 2: single CRP, constant response.
    mode = 0; resp_a = 16'hA5C3; pulses = 0; width_bad = 0; done_count = 0;
    sb.push_back('{ch: CH0, rsp: 16'hA5C3, stb: 16'hFFFF});
    run_start(16'd1);
    wait_done("t2", 200);
    check("t2_done_latency", 160'(done_cyc - start_cyc), 160'd83);
    check("t2_pulses", 160'(pulses), 160'd5);
    check("t2_pulse_width_bad", 160'(width_bad), 160'd0);
    repeat (5) @(negedge clk);
    #2;
    check("t2_done_once", 160'(done_count), 160'd1);
    check("t2_busy_after", {159'h0, busy}, 160'h0);

    // 3: votes 1-3 give 00FF, votes 4-5 give FF00.
    mode = 1; resp_a = 16'h00FF; resp_b = 16'hFF00; pulses = 0;
    sb.push_back('{ch: CH0, rsp: 16'h00FF, stb: STAB_MIXED});
    run_start(16'd1);
    wait_done("t3", 200);
    check("t3_pulses", 160'(pulses), 160'd5);

    // 4: three CRPs, ready low for 20 cycles on each.
    mode = 0; resp_a = 16'h3C5A; pulses = 0; valid_rises = 0;
    sb.push_back('{ch: CH0, rsp: 16'h3C5A, stb: 16'hFFFF});
    sb.push_back('{ch: CH1, rsp: 16'h3C5A, stb: 16'hFFFF});
    sb.push_back('{ch: CH2, rsp: 16'h3C5A, stb: 16'hFFFF});
    crp_if.crp_ready = 1'b0;
    run_start(16'd3);
    for (int k = 0; k < 3; k++) begin
      wait_valid(300);
      repeat (20) @(negedge clk);
      crp_if.crp_ready = 1'b1;
      @(negedge clk);
      crp_if.crp_ready = 1'b0;
    end
    wait_done("t4", 50);
    crp_if.crp_ready = 1'b1;
    check("t4_valid_rises", 160'(valid_rises), 160'd3);
    check("t4_sb_empty", 160'(sb.size()), 160'd0);

    // 5: zero-length run.
    pulses = 0; valid_rises = 0;
    run_start(16'd0);
    wait_done("t5", 20);
    check("t5_done_latency", 160'(done_cyc - start_cyc), 160'd1);
    repeat (5) @(negedge clk);
    #2;
    check("t5_no_trigger", 160'(pulses), 160'd0);
    check("t5_no_valid", 160'(valid_rises), 160'd0);

    // 6: reset during FIRE of the second vote, then a fresh run.
    pulses = 0;
    run_start(16'd1);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        #2;
        if (pulses == 2 && trigger) hit = 1'b1;
      end
      check("t6_second_fire", {159'h0, hit}, {159'h0, 1'b1});
    end
    reset = 1'b0;
    #1;
    check("t6_abort", {158'h0, trigger, busy}, 160'h0);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{ch: CH0, rsp: 16'h3C5A, stb: 16'hFFFF});
    run_start(16'd1);
    @(negedge clk);
    #2;
    check("t6_reload_challenge", {32'h0, challenge}, {32'h0, CH0});
    wait_done("t6", 200);
    repeat (3) @(negedge clk);
    #2;
    check("final_sb_empty", 160'(sb.size()), 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
